// File: rtl/kamus_lsu.sv
// kamus_lsu -- single-outstanding load/store unit between EX and a simple
// req/gnt/rvalid memory port.
//
// Ports
//   clk_i, rst_ni             clock, synchronous active-low reset
//   req_valid_i / req_ready_o EX request handshake (ready only when idle)
//   req_we_i, req_width_i     store flag, access width (B=00, H=01, W=10)
//   req_unsigned_i            zero-extend loads (LBU/LHU)
//   req_addr_i, req_wdata_i   byte address, right-aligned store data
//   req_rd_i                  destination register, echoed on resp_rd_o
//   mem_req_o / mem_gnt_i     memory request handshake
//   mem_addr_o, mem_we_o      word address, write enable
//   mem_be_o, mem_wdata_o     byte enables, lane-replicated store data
//   mem_rvalid_i, mem_rdata_i read data / write ack
//   resp_valid_o / resp_ready_i  response handshake towards WB
//   resp_rdata_o, resp_rd_o, resp_err_o  extended load data, rd, error code
module kamus_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_width_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic [4:0]  resp_rd_o,
    output logic [1:0]  resp_err_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    localparam logic [1:0] W_B = 2'b00;
    localparam logic [1:0] W_H = 2'b01;
    localparam logic [1:0] W_W = 2'b10;
    localparam logic [1:0] W_ILL = 2'b11;
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_e      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        we_reg, uns_reg;
    logic [1:0]  width_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [4:0]  rd_reg;
    logic [31:0] rdata_reg, rdata_next;
    logic [1:0]  err_reg, err_next;

    logic        handshake;
    logic        misaligned;
    logic [3:0]  be_calc;
    logic [31:0] wdata_rep;
    logic [31:0] lane;
    logic [31:0] load_ext;

    assign handshake = req_valid_i && (state_reg == S_IDLE);
    assign misaligned = ((req_width_i == W_H) && req_addr_i[0]) ||
                        ((req_width_i == W_W) && (req_addr_i[1:0] != 2'b00));

    // Per-lane byte enable and store-data replication from the latched request.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign be_calc[gi] = (width_reg == W_W) ||
                             ((width_reg == W_H) && (addr_reg[1] == 1'(gi / 2))) ||
                             ((width_reg == W_B) && (addr_reg[1:0] == 2'(gi)));
        assign wdata_rep[8*gi +: 8] = (width_reg == W_B) ? wdata_reg[7:0] :
                                      (width_reg == W_H) ? wdata_reg[8*(gi%2) +: 8] :
                                                           wdata_reg[8*gi +: 8];
    end

    // Shift the addressed byte/halfword down to bit 0, then extend.
    assign lane = mem_rdata_i >> {addr_reg[1:0], 3'b000};

    always_comb begin
        load_ext = mem_rdata_i;
        case (width_reg)
            W_B:     load_ext = {{24{~uns_reg & lane[7]}}, lane[7:0]};
            W_H:     load_ext = {{16{~uns_reg & lane[15]}}, lane[15:0]};
            default: load_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid_i) begin
                    rdata_next = '0;
                    if (req_width_i == W_ILL) begin
                        state_next = S_RESP;
                        err_next   = 2'b11;
                    end else if (misaligned) begin
                        state_next = S_RESP;
                        err_next   = 2'b01;
                    end else begin
                        state_next = S_REQ;
                        err_next   = 2'b00;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_next = S_WAIT;
                    cnt_next   = '0;
                end
            end
            S_WAIT: begin
                // rvalid is checked first so it wins over a same-cycle timeout.
                if (mem_rvalid_i) begin
                    state_next = S_RESP;
                    err_next   = 2'b00;
                    rdata_next = we_reg ? 32'd0 : load_ext;
                end else if (cnt_reg + 8'd1 == TIMEOUT_LIM) begin
                    state_next = S_RESP;
                    err_next   = 2'b10;
                    rdata_next = '0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            width_reg <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rd_reg    <= '0;
            rdata_reg <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            if (handshake) begin
                we_reg    <= req_we_i;
                uns_reg   <= req_unsigned_i;
                width_reg <= req_width_i;
                addr_reg  <= req_addr_i;
                wdata_reg <= req_wdata_i;
                rd_reg    <= req_rd_i;
            end
        end
    end

    // Memory-side outputs are only driven while a request is on the bus.
    assign req_ready_o  = (state_reg == S_IDLE);
    assign mem_req_o    = (state_reg == S_REQ);
    assign mem_addr_o   = mem_req_o ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign mem_we_o     = mem_req_o & we_reg;
    assign mem_be_o     = mem_req_o ? be_calc : 4'b0000;
    assign mem_wdata_o  = mem_req_o ? wdata_rep : 32'd0;
    assign resp_valid_o = (state_reg == S_RESP);
    assign resp_rdata_o = rdata_reg;
    assign resp_rd_o    = rd_reg;
    assign resp_err_o   = err_reg;

endmodule

// File: tb/tb_kamus_lsu.sv
module tb_kamus_lsu;
    localparam int T = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_width_i = '0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_rdata_o;
    logic [4:0]  resp_rd_o;
    logic [1:0]  resp_err_o;

    int n_checks = 0;
    int n_pass = 0;

    kamus_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_width_i(req_width_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_rd_o(resp_rd_o),
        .resp_err_o(resp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] exp_err(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'd3) return 2'd3;
        if (w == 2'd1 && (a % 2) != 0) return 2'd1;
        if (w == 2'd2 && (a % 4) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'd0) return 4'(1 << (a % 4));
        if (w == 2'd1) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] w, input logic [31:0] d);
        if (w == 2'd0) return (d % 256) * 32'h0101_0101;
        if (w == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] w, input logic u,
                                              input logic [31:0] a, input logic [31:0] r);
        logic [31:0] s;
        logic [31:0] v;
        s = r / (32'd1 << (8 * (a % 4)));
        if (w == 2'd0) begin
            v = s % 256;
            if (!u && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (w == 2'd1) begin
            v = s % 65536;
            if (!u && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return r;
    endfunction

    // One full transaction: EX request, memory agent with the given delays,
    // WB stalling for rrdy_dly cycles. rv_dly >= T means the memory never answers.
    task automatic do_txn(input logic we, input logic [1:0] w, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input int rrdy_dly);
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
        int          cycles;
        e_err = exp_err(w, a);
        check("idle_ready", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_we_i = we; req_width_i = w; req_unsigned_i = u;
        req_addr_i = a; req_wdata_i = d; req_rd_i = rd;
        step();
        req_valid_i = 1'b0;
        req_addr_i = $urandom; req_wdata_i = $urandom; req_rd_i = 5'($urandom);
        e_rdata = 32'd0;
        if (e_err != 2'd0) begin
            check("err_no_memreq", 32'(mem_req_o), 32'd0);
            check("err_resp_next", 32'(resp_valid_o), 32'd1);
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                check("mem_req", 32'(mem_req_o), 32'd1);
                check("mem_addr", mem_addr_o, a & 32'hFFFF_FFFC);
                check("mem_we", 32'(mem_we_o), 32'(we));
                check("mem_be", 32'(mem_be_o), 32'(exp_be(w, a)));
                check("mem_wdata", mem_wdata_o, we ? exp_wdata(w, d) : mem_wdata_o);
                mem_gnt_i = (i == gnt_dly);
                step();
                mem_gnt_i = 1'b0;
            end
            check("wait_no_req", 32'(mem_req_o), 32'd0);
            cycles = 0;
            while (!resp_valid_o && cycles < 300) begin
                mem_rvalid_i = (cycles == rv_dly);
                mem_rdata_i = (cycles == rv_dly) ? rdata : $urandom;
                step();
                mem_rvalid_i = 1'b0;
                cycles++;
            end
            if (rv_dly < T) begin
                e_rdata = we ? 32'd0 : exp_load(w, u, a, rdata);
                check("wait_cycles", 32'(cycles), 32'(rv_dly + 1));
            end else begin
                e_err = 2'd2;
                check("timeout_cycles", 32'(cycles), 32'(T));
            end
        end
        check("resp_valid", 32'(resp_valid_o), 32'd1);
        check("resp_rdata", resp_rdata_o, e_rdata);
        check("resp_err", 32'(resp_err_o), 32'(e_err));
        check("resp_rd", 32'(resp_rd_o), 32'(rd));
        for (int k = 0; k < rrdy_dly; k++) begin
            req_valid_i = 1'($urandom);
            step();
            check("stall_valid", 32'(resp_valid_o), 32'd1);
            check("stall_rdata", resp_rdata_o, e_rdata);
            check("stall_err", 32'(resp_err_o), 32'(e_err));
            check("stall_not_ready", 32'(req_ready_o), 32'd0);
        end
        // Offer a legal request in the accepting cycle; it must not be taken.
        resp_ready_i = 1'b1; req_valid_i = 1'b1; req_width_i = 2'd2;
        req_addr_i = 32'h0000_0040; req_we_i = 1'b0;
        step();
        resp_ready_i = 1'b0; req_valid_i = 1'b0;
        check("resp_done", 32'(resp_valid_o), 32'd0);
        check("no_same_cycle_accept", 32'(mem_req_o), 32'd0);
        $display("txn we=%0d w=%0d u=%0d addr=%h gnt_dly=%0d rv_dly=%0d err=%0d rdata=%h",
                 we, w, u, a, gnt_dly, rv_dly, e_err, e_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        repeat (3) step();
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_be", 32'(mem_be_o), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_resp_err", 32'(resp_err_o), 32'd0);
        rst_ni = 1'b1;
        step();

        // Directed cases
        do_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd3, 0, 0, 32'h80FF_FF00, 0);
        do_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD, 5'd4, 3, 1, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h301, 32'h0, 5'd5, 0, 0, 32'h0, 0);
        do_txn(1'b0, 2'd1, 1'b1, 32'h301, 32'h0, 5'd6, 0, 0, 32'h0, 0);
        do_txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 5'd7, 0, 0, 32'h0, 0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd8, 0, 99, 32'h0, 0);
        // Late data after the timeout is ignored.
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
        step();
        mem_rvalid_i = 1'b0;
        check("late_rvalid_ignored", 32'(resp_valid_o), 32'd0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 5'd9, 0, 0, 32'hCAFE_F00D, 0);
        // rvalid on the last WAIT cycle still wins over the timeout.
        do_txn(1'b0, 2'd1, 1'b0, 32'h406, 32'h0, 5'd10, 1, T - 1, 32'h8001_0000, 0);
        do_txn(1'b0, 2'd1, 1'b1, 32'h406, 32'h0, 5'd11, 0, 2, 32'h8001_0000, 5);

        // Reset while waiting for data aborts the access.
        req_valid_i = 1'b1; req_we_i = 1'b1; req_width_i = 2'd0;
        req_addr_i = 32'h501; req_wdata_i = 32'h77; req_rd_i = 5'd17;
        step();
        req_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check("wrst_ready", 32'(req_ready_o), 32'd1);
        check("wrst_mem_req", 32'(mem_req_o), 32'd0);
        check("wrst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("wrst_rdata", resp_rdata_o, 32'd0);
        check("wrst_rd", 32'(resp_rd_o), 32'd0);
        check("wrst_err", 32'(resp_err_o), 32'd0);
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        check("stale_rvalid", 32'(resp_valid_o), 32'd0);
        step();
        check("stale_rvalid_2", 32'(resp_valid_o), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [1:0] w;
            int rv;
            w = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rv = ($urandom_range(0, 7) == 0) ? T + 4 : int'($urandom_range(0, 5));
            do_txn(1'($urandom), w, 1'($urandom), $urandom, $urandom, 5'($urandom),
                   int'($urandom_range(0, 3)), rv, $urandom, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/kamus_lsu.md
KAMUS_LSU -- requirements
Module: kamus_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max cycles in WAIT before a bus-timeout error; legal range 1..255.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  synchronous active-low reset.
REQ-005 req_valid_i  in  1  access request from EX.
REQ-006 req_ready_o  out  1  LSU can accept a request.
REQ-007 req_we_i  in  1  1 = store, 0 = load.
REQ-008 req_width_i  in  2  mem_width_e: B=00, H=01, W=10; 11 is illegal.
REQ-009 req_unsigned_i  in  1  load zero-extends (LBU/LHU); ignored for stores.
REQ-010 req_addr_i  in  32  byte address.
REQ-011 req_wdata_i  in  32  store data, right-aligned.
REQ-012 req_rd_i  in  5  destination register; returned with response.
REQ-013 mem_req_o  out  1  memory request.
REQ-014 mem_gnt_i  in  1  memory accepted request this cycle.
REQ-015 mem_addr_o  out  32  word address: req_addr with [1:0] forced to 00.
REQ-016 mem_we_o  out  1  write enable.
REQ-017 mem_be_o  out  4  byte enables.
REQ-018 mem_wdata_o  out  32  lane-replicated store data.
REQ-019 mem_rvalid_i  in  1  read data / write ack valid.
REQ-020 mem_rdata_i  in  32  read data word.
REQ-021 resp_valid_o  out  1  response valid.
REQ-022 resp_ready_i  in  1  WB accepts response.
REQ-023 resp_rdata_o  out  32  extended load data; 0 for stores and errors.
REQ-024 resp_rd_o  out  5  latched req_rd_i.
REQ-025 resp_err_o  out  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal width.

Function
REQ-026 FSM states IDLE, REQ, WAIT, RESP; req_ready_o = 1 only in IDLE; handshake = req_valid_i & req_ready_o.
REQ-027 On handshake, latch we, width, unsigned, addr, wdata, rd; illegal width -> RESP with err 11; misaligned (H with addr[0]=1, W with addr[1:0]!=00) -> RESP with err 01; otherwise -> REQ. Errored requests never assert mem_req_o.
REQ-028 REQ: mem_req_o = 1 with stable addr/we/be/wdata until the cycle mem_gnt_i = 1; then -> WAIT.
REQ-029 WAIT: mem_req_o = 0; counter cleared on entry, +1 per cycle; mem_rvalid_i = 1 -> RESP err 00; counter reaching TIMEOUT_CYCLES without rvalid -> RESP err 10.
REQ-030 rvalid and timeout in the same cycle: rvalid wins (err 00).
REQ-031 RESP: resp_valid_o = 1 with stable data/rd/err until resp_ready_i = 1; then -> IDLE; no new request accepted in the same cycle.
REQ-032 mem_rvalid_i outside WAIT (incl. late data after timeout) is ignored.
REQ-033 mem_be_o: B = 0001 << addr[1:0]; H = 0011 (addr[1]=0) or 1100 (addr[1]=1); W = 1111.
REQ-034 mem_wdata_o: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-035 Load data: lane = mem_rdata_i >> (8*addr[1:0]); B/H sign- or zero-extended per req_unsigned_i from bit 7/15; W passthrough; data registered at rvalid.
REQ-036 Minimum latency: handshake cycle 0, mem_req_o cycle 1; with gnt cycle 1 and rvalid cycle 2, resp_valid_o in cycle 3.
REQ-037 Misaligned or illegal-width latency: resp_valid_o in the cycle after handshake.

Reset
REQ-038 With rst_ni = 0 at a clock edge: state IDLE, counter 0, all latches 0; outputs mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, resp_valid_o=0, resp_rdata_o=0, resp_rd_o=0, resp_err_o=00, req_ready_o=1.
REQ-039 Reset in REQ/WAIT/RESP aborts the access with no response; a subsequent stale rvalid is ignored per REQ-032.

Verification
REQ-040 LB addr 0x103, unsigned 0, rdata 0x80FF_FF00 -> mem_addr 0x100, be 1000, resp_rdata 0xFFFF_FF80, err 00.
REQ-041 SH addr 0x202, wdata 0x1234_ABCD, gnt delayed 3 cycles -> mem_req held 4 cycles, be 1100, wdata 0xABCD_ABCD; response after rvalid, rdata 0.
REQ-042 LW addr 0x301 -> no mem_req, resp_valid next cycle, err 01; LHU addr 0x301 -> err 01; width 11 -> err 11.
REQ-043 LW granted, no rvalid, TIMEOUT_CYCLES=16 -> err 10 after 16 WAIT cycles; rvalid 2 cycles later ignored, next request served normally.
REQ-044 resp_ready_i low for 5 cycles -> resp outputs stable, req_ready_o = 0; then rst_ni = 0 during WAIT -> all outputs at reset values next cycle.
